// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch-stage, memory-stage and SRAM-side signals of the shared
// instruction/data SRAM port.
// Signal names use the arbiter's own direction prefixes:
//   i_* : driven into the arbiter (requesters and SRAM read data)
//   o_* : driven by the arbiter (SRAM controls, returned data, handshakes, stalls)
// Modports:
//   slave  : used by the arbiter itself
//   master : used by whatever drives the arbiter (pipeline model / testbench)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic              i_if_flush;
   logic              i_mem_rd;
   logic              i_mem_wr;
   logic [ADDR_W-1:0] i_mem_addr;
   logic [DATA_W-1:0] i_mem_wdata;
   logic [DATA_W-1:0] i_sram_rdata;
   logic              o_sram_en;
   logic              o_sram_we;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [DATA_W-1:0] o_sram_wdata;
   logic [DATA_W-1:0] o_if_instr;
   logic              o_if_ready;
   logic [DATA_W-1:0] o_mem_rdata;
   logic              o_mem_ready;
   logic              o_if_stall;
   logic              o_mem_stall;

   modport slave (
      input  i_if_req, i_if_addr, i_if_flush, i_mem_rd, i_mem_wr,
             i_mem_addr, i_mem_wdata, i_sram_rdata,
      output o_sram_en, o_sram_we, o_sram_addr, o_sram_wdata, o_if_instr,
             o_if_ready, o_mem_rdata, o_mem_ready, o_if_stall, o_mem_stall
   );

   modport master (
      output i_if_req, i_if_addr, i_if_flush, i_mem_rd, i_mem_wr,
             i_mem_addr, i_mem_wdata, i_sram_rdata,
      input  o_sram_en, o_sram_we, o_sram_addr, o_sram_wdata, o_if_instr,
             o_if_ready, o_mem_rdata, o_mem_ready, o_if_stall, o_mem_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported fixed-latency SRAM between the fetch stage and the
// memory stage. One request is served at a time: IDLE grants, ACCESS drives
// the SRAM for WAIT_CYCLES cycles, DONE pulses the ready of the granted side.
// Contention is resolved round-robin against the previous grant. A branch
// flush during a fetch access lets the SRAM access finish but suppresses the
// instruction capture and the if_ready pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (requests, SRAM bus, data, ready, stalls)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic       G_FETCH  = 1'b0;
   localparam logic       G_DATA   = 1'b1;
   localparam logic [3:0] LP_WAIT  = 4'(WAIT_CYCLES);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_grant;
   logic              r_last_grant;
   logic              r_cancel;
   logic              r_sram_en;
   logic              r_sram_we;
   logic [ADDR_W-1:0] r_sram_addr;
   logic [DATA_W-1:0] r_sram_wdata;
   logic [DATA_W-1:0] r_if_instr;
   logic              r_if_ready;
   logic [DATA_W-1:0] r_mem_rdata;
   logic              r_mem_ready;

   logic w_fetch_pend;
   logic w_data_pend;
   logic w_grant_nxt;
   logic w_cancel;

   // Request decode, round-robin grant choice and effective cancel for this cycle.
   always_comb begin
      w_fetch_pend = bus.i_if_req;
      w_data_pend  = bus.i_mem_rd | bus.i_mem_wr;
      if (w_fetch_pend && w_data_pend) begin
         w_grant_nxt = ~r_last_grant;
      end else if (w_data_pend) begin
         w_grant_nxt = G_DATA;
      end else begin
         w_grant_nxt = G_FETCH;
      end
      // A flush in the final ACCESS cycle must already block the capture, so
      // the live flush is merged with the stored flag. A flush that arrives in
      // DONE is too late: the instruction has been delivered by then.
      if ((r_state == S_ACCESS) && (r_grant == G_FETCH)) begin
         w_cancel = r_cancel | bus.i_if_flush;
      end else begin
         w_cancel = r_cancel;
      end
   end

   // Access sequencer: grant, SRAM drive, data capture and ready pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_grant      <= G_FETCH;
         r_last_grant <= G_FETCH;
         r_cancel     <= 1'b0;
         r_sram_en    <= 1'b0;
         r_sram_we    <= 1'b0;
         r_sram_addr  <= {ADDR_W{1'b0}};
         r_sram_wdata <= {DATA_W{1'b0}};
         r_if_instr   <= {DATA_W{1'b0}};
         r_if_ready   <= 1'b0;
         r_mem_rdata  <= {DATA_W{1'b0}};
         r_mem_ready  <= 1'b0;
      end else begin
         r_if_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fetch_pend || w_data_pend) begin
                  // The SRAM drive registers double as the request latch.
                  r_grant   <= w_grant_nxt;
                  r_cnt     <= LP_WAIT;
                  r_state   <= S_ACCESS;
                  r_sram_en <= 1'b1;
                  if (w_grant_nxt == G_DATA) begin
                     r_sram_we    <= bus.i_mem_wr;
                     r_sram_addr  <= bus.i_mem_addr;
                     r_sram_wdata <= bus.i_mem_wr ? bus.i_mem_wdata : {DATA_W{1'b0}};
                  end else begin
                     r_sram_we    <= 1'b0;
                     r_sram_addr  <= bus.i_if_addr;
                     r_sram_wdata <= {DATA_W{1'b0}};
                  end
               end
            end
            S_ACCESS: begin
               r_cnt    <= r_cnt - 4'd1;
               r_cancel <= w_cancel;
               if (r_cnt == 4'd1) begin
                  r_state      <= S_DONE;
                  r_sram_en    <= 1'b0;
                  r_sram_we    <= 1'b0;
                  r_sram_addr  <= {ADDR_W{1'b0}};
                  r_sram_wdata <= {DATA_W{1'b0}};
                  if (r_grant == G_FETCH) begin
                     if (!w_cancel) begin
                        r_if_instr <= bus.i_sram_rdata;
                        r_if_ready <= 1'b1;
                     end
                  end else begin
                     r_mem_ready <= 1'b1;
                     if (!r_sram_we) begin
                        r_mem_rdata <= bus.i_sram_rdata;
                     end
                  end
               end
            end
            S_DONE: begin
               r_last_grant <= r_grant;
               r_cancel     <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_cancel  <= 1'b0;
               r_sram_en <= 1'b0;
               r_sram_we <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_sram_en    = r_sram_en;
   assign bus.o_sram_we    = r_sram_we;
   assign bus.o_sram_addr  = r_sram_addr;
   assign bus.o_sram_wdata = r_sram_wdata;
   assign bus.o_if_instr   = r_if_instr;
   assign bus.o_if_ready   = r_if_ready;
   assign bus.o_mem_rdata  = r_mem_rdata;
   assign bus.o_mem_ready  = r_mem_ready;
   // Stalls follow the live requests so the pipeline freezes in the request cycle.
   assign bus.o_if_stall   = bus.i_if_req & ~r_if_ready;
   assign bus.o_mem_stall  = (bus.i_mem_rd | bus.i_mem_wr) & ~r_mem_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiters (WAIT_CYCLES=2 and WAIT_CYCLES=1) driven by random fetch/data
// requesters that follow the hold-until-ready protocol, with random flushes
// and random synchronous resets. A transaction-level model (grant time,
// access window, completion time, reference memory image) predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // stimulus per instance
   logic        req_if[2], flush[2], rd[2], wr[2];
   logic [31:0] addr_if[2], maddr[2], wdata[2];
   logic        p_ifr[2], p_mr[2];
   // observed outputs per instance
   logic        o_en[2], o_we[2], o_ifr[2], o_mr[2], o_ifs[2], o_ms[2];
   logic [31:0] o_addr[2], o_wd[2], o_instr[2], o_rdata[2];
   // SRAM contents behind each arbiter
   logic [31:0] sram[2][16];

   // reference model state
   int          W[2];
   bit          m_busy[2], m_ch[2], m_we[2], m_cancel[2], m_last[2];
   int          m_t[2];
   logic [31:0] m_addr[2], m_wd[2];
   logic [31:0] e_instr[2], e_rdata[2];
   bit          e_ifr[2], e_mr[2];
   logic [31:0] ref_mem[2][16];

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .bus(if0)
   );
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1)
   );

   assign if0.i_if_req     = req_if[0];
   assign if0.i_if_addr    = addr_if[0];
   assign if0.i_if_flush   = flush[0];
   assign if0.i_mem_rd     = rd[0];
   assign if0.i_mem_wr     = wr[0];
   assign if0.i_mem_addr   = maddr[0];
   assign if0.i_mem_wdata  = wdata[0];
   assign if0.i_sram_rdata = sram[0][if0.o_sram_addr[5:2]];
   assign if1.i_if_req     = req_if[1];
   assign if1.i_if_addr    = addr_if[1];
   assign if1.i_if_flush   = flush[1];
   assign if1.i_mem_rd     = rd[1];
   assign if1.i_mem_wr     = wr[1];
   assign if1.i_mem_addr   = maddr[1];
   assign if1.i_mem_wdata  = wdata[1];
   assign if1.i_sram_rdata = sram[1][if1.o_sram_addr[5:2]];

   assign o_en[0] = if0.o_sram_en;     assign o_en[1] = if1.o_sram_en;
   assign o_we[0] = if0.o_sram_we;     assign o_we[1] = if1.o_sram_we;
   assign o_addr[0] = if0.o_sram_addr; assign o_addr[1] = if1.o_sram_addr;
   assign o_wd[0] = if0.o_sram_wdata;  assign o_wd[1] = if1.o_sram_wdata;
   assign o_instr[0] = if0.o_if_instr; assign o_instr[1] = if1.o_if_instr;
   assign o_ifr[0] = if0.o_if_ready;   assign o_ifr[1] = if1.o_if_ready;
   assign o_rdata[0] = if0.o_mem_rdata; assign o_rdata[1] = if1.o_mem_rdata;
   assign o_mr[0] = if0.o_mem_ready;   assign o_mr[1] = if1.o_mem_ready;
   assign o_ifs[0] = if0.o_if_stall;   assign o_ifs[1] = if1.o_if_stall;
   assign o_ms[0] = if0.o_mem_stall;   assign o_ms[1] = if1.o_mem_stall;

   task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom();
      a[1:0] = 2'b00;
      return a;
   endfunction

   task automatic model_reset(input int k);
      m_busy[k] = 1'b0; m_cancel[k] = 1'b0; m_last[k] = 1'b0;
      e_instr[k] = 32'd0; e_rdata[k] = 32'd0;
   endtask

   // Compare the registered outputs of cycle cyc against the model.
   task automatic check_outputs(input int k);
      int d;
      bit acc;
      d        = m_busy[k] ? (cyc - m_t[k]) : -1;
      acc      = m_busy[k] && (d >= 1) && (d <= W[k]);
      e_ifr[k] = m_busy[k] && (d == W[k] + 1) && !m_ch[k] && !m_cancel[k];
      e_mr[k]  = m_busy[k] && (d == W[k] + 1) && m_ch[k];
      tb_check($sformatf("sram_en%0d", k), 32'(o_en[k]), 32'(acc));
      tb_check($sformatf("sram_we%0d", k), 32'(o_we[k]), 32'(acc && m_we[k]));
      tb_check($sformatf("sram_addr%0d", k), o_addr[k], acc ? m_addr[k] : 32'd0);
      if (acc && m_we[k]) begin
         tb_check($sformatf("sram_wdata%0d", k), o_wd[k], m_wd[k]);
         ref_mem[k][m_addr[k][5:2]] = m_wd[k];
      end else if (!acc) begin
         tb_check($sformatf("sram_wdata_idle%0d", k), o_wd[k], 32'd0);
      end
      tb_check($sformatf("if_ready%0d", k), 32'(o_ifr[k]), 32'(e_ifr[k]));
      tb_check($sformatf("mem_ready%0d", k), 32'(o_mr[k]), 32'(e_mr[k]));
      tb_check($sformatf("if_instr%0d", k), o_instr[k], e_instr[k]);
      tb_check($sformatf("mem_rdata%0d", k), o_rdata[k], e_rdata[k]);
      // SRAM commits whatever the arbiter drives
      if (o_en[k] && o_we[k]) sram[k][o_addr[k][5:2]] = o_wd[k];
   endtask

   // Random requesters: hold until the ready seen in the previous cycle.
   task automatic drive_inputs(input int k);
      flush[k] = ($urandom_range(0, 9) == 0);
      if (req_if[k]) begin
         if (p_ifr[k]) begin
            req_if[k]  = ($urandom_range(0, 2) != 0);
            addr_if[k] = rnd_addr();
         end else if (flush[k]) begin
            addr_if[k] = rnd_addr();
         end
      end else if ($urandom_range(0, 2) == 0) begin
         req_if[k]  = 1'b1;
         addr_if[k] = rnd_addr();
      end
      if ((rd[k] || wr[k]) && p_mr[k] && ($urandom_range(0, 1) == 0)) begin
         rd[k] = 1'b0; wr[k] = 1'b0;
      end else if ((!rd[k] && !wr[k] && ($urandom_range(0, 2) == 0)) ||
                   ((rd[k] || wr[k]) && p_mr[k])) begin
         case ($urandom_range(0, 3))
            0, 1:    begin rd[k] = 1'b1; wr[k] = 1'b0; end
            2:       begin rd[k] = 1'b0; wr[k] = 1'b1; end
            default: begin rd[k] = 1'b1; wr[k] = 1'b1; end
         endcase
         maddr[k] = rnd_addr();
         wdata[k] = $urandom();
      end
   endtask

   // Advance the transaction model with the inputs of cycle cyc.
   task automatic model_step(input int k);
      int d;
      bit dp;
      if (rst) begin
         model_reset(k);
      end else if (!m_busy[k]) begin
         dp = rd[k] | wr[k];
         if (req_if[k] || dp) begin
            m_ch[k]     = (req_if[k] && dp) ? ~m_last[k] : dp;
            m_busy[k]   = 1'b1;
            m_t[k]      = cyc;
            m_cancel[k] = 1'b0;
            if (m_ch[k]) begin
               m_we[k] = wr[k]; m_addr[k] = maddr[k];
               m_wd[k] = wr[k] ? wdata[k] : 32'd0;
            end else begin
               m_we[k] = 1'b0; m_addr[k] = addr_if[k]; m_wd[k] = 32'd0;
            end
         end
      end else begin
         d = cyc - m_t[k];
         if (!m_ch[k] && flush[k] && (d >= 1) && (d <= W[k])) m_cancel[k] = 1'b1;
         if (d == W[k]) begin
            if (!m_ch[k]) begin
               if (!m_cancel[k]) e_instr[k] = ref_mem[k][m_addr[k][5:2]];
            end else if (!m_we[k]) begin
               e_rdata[k] = ref_mem[k][m_addr[k][5:2]];
            end
         end
         if (d == W[k] + 1) begin
            m_last[k] = m_ch[k]; m_busy[k] = 1'b0; m_cancel[k] = 1'b0;
         end
      end
   endtask

   initial begin
      W[0] = 2; W[1] = 1;
      for (int k = 0; k < 2; k++) begin
         req_if[k] = 1'b0; flush[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
         addr_if[k] = 32'd0; maddr[k] = 32'd0; wdata[k] = 32'd0;
         p_ifr[k] = 1'b0; p_mr[k] = 1'b0;
         for (int i = 0; i < 16; i++) begin
            sram[k][i]    = $urandom();
            ref_mem[k][i] = sram[k][i];
         end
         model_reset(k);
      end
      rst = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) check_outputs(k);
         rst = (cyc < 3) || ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 2; k++) drive_inputs(k);
         #1;
         for (int k = 0; k < 2; k++) begin
            tb_check($sformatf("if_stall%0d", k), 32'(o_ifs[k]), 32'(req_if[k] & ~e_ifr[k]));
            tb_check($sformatf("mem_stall%0d", k), 32'(o_ms[k]), 32'((rd[k] | wr[k]) & ~e_mr[k]));
         end
         for (int k = 0; k < 2; k++) begin
            model_step(k);
            p_ifr[k] = o_ifr[k];
            p_mr[k]  = o_mr[k];
         end
         cyc++;
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
